csr_counters: RTL



---
 rtl/csr_counters.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/csr_counters.sv
// csr_counters: machine-mode counter/ID CSR file.
//   mcycle, minstret, NUM_HPM mhpmcounters (all 64-bit internally), their
//   mhpmevent selectors, mcountinhibit, user read-only shadows, misa and the
//   F11-F14 identification registers.
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   wen, addr, wdata    - one write port; addr also drives the read port
//   is_done_inst        - one instruction retired this cycle
//   events              - per-cycle event pulses, bit k is event k+1
//   rdata               - combinational read of addr (0 when unimplemented)
//   illegal             - addr unimplemented, or wen to a read-only CSR

// One 64-bit counter. A write replaces the masked bits, keeps the rest and
// suppresses that cycle's increment.
module csr_counters_ctr (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr,
  input  logic [63:0] wr_mask,
  input  logic [63:0] wr_val,
  output logic [63:0] cnt
);
  always_ff @(posedge clock) begin
    if (reset)    cnt <= '0;
    else if (wr)  cnt <= (cnt & ~wr_mask) | (wr_val & wr_mask);
    else if (inc) cnt <= cnt + 64'd1;
  end
endmodule

module csr_counters #(
  parameter int              XLEN       = 32,
  parameter int              NUM_HPM    = 4,
  parameter int              NUM_EVENTS = 8,
  parameter logic [31:0]     HART_ID    = 32'd0,
  parameter logic [XLEN-1:0] MISA_VAL   = XLEN'(32'h40000100)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [11:0]           addr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  is_done_inst,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [XLEN-1:0]       rdata,
  output logic                  illegal
);
  localparam int S  = $clog2(NUM_EVENTS + 1);
  localparam int NC = 2 + NUM_HPM;               // 0: mcycle, 1: minstret, 2+j: hpm(3+j)
  localparam int NH = (NUM_HPM == 0) ? 1 : NUM_HPM;
  // Writable mcountinhibit bits: CY, IR and one per implemented hpm counter.
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [NC-1:0][63:0] cnt;
  logic [NC-1:0]       wr_c;
  logic [NH-1:0][S-1:0] evt_sel;
  logic [NH-1:0]       ev_hit;
  logic [31:0]         mcinh;

  logic [4:0]  ia;
  logic [6:0]  blk;
  logic [4:0]  ctr_idx;
  logic        ctr_ok, is_m_lo, is_m_hi, is_u_lo, is_u_hi, is_ctr;
  logic        is_inh, is_evt, is_misa, is_id, impl, ro, wr_ok;
  logic [63:0] cnt_sel, wr_mask, wr_val;
  logic [S-1:0] evt_rd;

  // Address decode. Counter CSRs share a 32-entry block layout: offset 0 is
  // the cycle counter, 2 instret, 3.. the hpm counters; offset 1 (time) is
  // absent from this block.
  always_comb begin
    ia      = addr[4:0];
    blk     = addr[11:5];
    ctr_ok  = (ia == 5'd0) || (ia == 5'd2) ||
              (int'(ia) >= 3 && int'(ia) < 3 + NUM_HPM);
    ctr_idx = (ia == 5'd0) ? 5'd0 : ia - 5'd1;
    is_m_lo = (blk == 7'h58);
    is_m_hi = (blk == 7'h5C) && (XLEN == 32);
    is_u_lo = (blk == 7'h60);
    is_u_hi = (blk == 7'h64) && (XLEN == 32);
    is_ctr  = ctr_ok && (is_m_lo || is_m_hi || is_u_lo || is_u_hi);
    is_inh  = (addr == 12'h320);
    is_evt  = (blk == 7'h19) && int'(ia) >= 3 && int'(ia) < 3 + NUM_HPM;
    is_misa = (addr == 12'h301);
    is_id   = (addr >= 12'hF11) && (addr <= 12'hF14);
    impl    = is_ctr || is_inh || is_evt || is_misa || is_id;
    ro      = is_id || (is_ctr && (is_u_lo || is_u_hi));
    illegal = !impl || (wen && ro);
    wr_ok   = wen && !illegal;
  end

  // Read mux
  always_comb begin
    cnt_sel = '0;
    for (int c = 0; c < NC; c++)
      if (ctr_idx == 5'(c)) cnt_sel = cnt[c];
    evt_rd = '0;
    for (int j = 0; j < NUM_HPM; j++)
      if (ia == 5'(j + 3)) evt_rd = evt_sel[j];
    rdata = '0;
    if (is_ctr)       rdata = (is_m_hi || is_u_hi) ? XLEN'(cnt_sel[63:32]) : XLEN'(cnt_sel);
    else if (is_inh)  rdata = XLEN'(mcinh);
    else if (is_evt)  rdata = XLEN'(evt_rd);
    else if (is_misa) rdata = MISA_VAL;
    else begin
      case (addr)
        12'hF11: rdata = XLEN'(32'h62656B61);   // "beka"
        12'hF12: rdata = XLEN'(32'h05318008);
        12'hF14: rdata = XLEN'(HART_ID);
        default: rdata = '0;                    // mimpid and unimplemented
      endcase
    end
  end

  // Counter write data: full width at XLEN=64, else the addressed half.
  always_comb begin
    if (XLEN == 64) begin
      wr_mask = '1;
      wr_val  = 64'(wdata);
    end else if (is_m_hi) begin
      wr_mask = {32'hFFFF_FFFF, 32'h0};
      wr_val  = {wdata[31:0], 32'h0};
    end else begin
      wr_mask = {32'h0, 32'hFFFF_FFFF};
      wr_val  = {32'h0, wdata[31:0]};
    end
    wr_c = '0;
    for (int c = 0; c < NC; c++)
      wr_c[c] = wr_ok && (is_m_lo || is_m_hi) && ctr_ok && (ctr_idx == 5'(c));
  end

  // Selector and inhibit state. Increments this cycle use the values held
  // before the edge, so a write only affects counting from the next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcinh   <= '0;
      evt_sel <= '0;
    end else if (wr_ok) begin
      if (is_inh) mcinh <= wdata[31:0] & INH_MASK;
      for (int j = 0; j < NUM_HPM; j++)
        if (is_evt && ia == 5'(j + 3)) evt_sel[j] <= wdata[S-1:0];
    end
  end

  // Event match: selector k in 1..NUM_EVENTS picks events[k-1]; anything
  // else (0 or out of range) counts nothing.
  if (NUM_HPM == 0) begin : g_no_hpm
    assign ev_hit = '0;
  end
  for (genvar j = 0; j < NUM_HPM; j++) begin : g_evt
    always_comb begin
      ev_hit[j] = 1'b0;
      for (int k = 1; k <= NUM_EVENTS; k++)
        if (evt_sel[j] == S'(k)) ev_hit[j] = events[k-1];
    end
  end

  for (genvar c = 0; c < NC; c++) begin : g_ctr
    logic inc;
    if (c == 0)      begin : g_cy assign inc = ~mcinh[0]; end
    else if (c == 1) begin : g_ir assign inc = is_done_inst & ~mcinh[2]; end
    else             begin : g_hp assign inc = ev_hit[c-2] & ~mcinh[c+1]; end

    csr_counters_ctr u_ctr (
      .clock   (clock),
      .reset   (reset),
      .inc     (inc),
      .wr      (wr_c[c]),
      .wr_mask (wr_mask),
      .wr_val  (wr_val),
      .cnt     (cnt[c])
    );
  end
endmodule
